// File: rtl/pipe_hold_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hold_ctrl_pkg : shared hold-bus encodings and FSM state values.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_hold_ctrl_pkg;

  localparam int          c_INST_ADDR_W = 32;
  localparam logic [2:0]  c_HOLD_NONE   = 3'd0;
  localparam logic [2:0]  c_HOLD_PC     = 3'd1;
  localparam logic [2:0]  c_HOLD_ID     = 3'd3;
  localparam logic [31:0] c_ZERO_WORD   = 32'h0000_0000;
  localparam logic        c_RST_ENABLE  = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  function automatic logic [2:0] hold_max(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hold_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hold_ctrl_if : request/redirect/status bundle of the controller. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pipe_hold_ctrl_if #(
  parameter int CNT_W = 16
);
  logic              jump_flag_i;
  logic [31:0]       jump_addr_i;
  logic              hold_flag_ex_i;
  logic              hold_flag_rib_i;
  logic              hold_flag_clint_i;
  logic              jtag_halt_req_i;
  logic [2:0]        hold_flag_o;
  logic              jump_flag_o;
  logic [31:0]       jump_addr_o;
  logic              halted_o;
  logic              stall_timeout_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i,
           hold_flag_clint_i, jtag_halt_req_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, halted_o,
           stall_timeout_o, stall_cnt_o
  );

  modport master (
    output jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i,
           hold_flag_clint_i, jtag_halt_req_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, halted_o,
           stall_timeout_o, stall_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hold_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hold_ctrl_sat_counter : saturating up-counter with sync clear.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_hold_ctrl_sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_inc,
  input  wire logic             i_clr,
  output logic [WIDTH-1:0]      o_count,
  output logic [WIDTH-1:0]      o_next
);
  import pipe_hold_ctrl_pkg::*;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Clear dominates increment; the count sticks at all-ones.
  always_comb begin
    w_next = r_count;
    if (i_clr)
      w_next = '0;
    else if (i_inc && !(&r_count))
      w_next = r_count + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == c_RST_ENABLE)
      r_count <= '0;
    else
      r_count <= w_next;
  end

  assign o_count = r_count;
  assign o_next  = w_next;

endmodule
`default_nettype wire

// File: rtl/pipe_hold_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hold_ctrl : pipeline hold/flush arbiter, debug halt, watchdog.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_hold_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_LIMIT  = 1024,
  parameter int CNT_W        = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipe_hold_ctrl_if.slave   bus
);
  import pipe_hold_ctrl_pkg::*;

  localparam logic [3:0]       c_FLUSH_RELOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
  localparam logic [CNT_W-1:0] c_STALL_LIMIT  = CNT_W'(STALL_LIMIT);

  state_t           r_state;
  logic [3:0]       r_flush_cnt;
  logic             r_halted;
  logic             r_timeout;
  logic [2:0]       w_hold;
  logic             w_req_id;
  logic             w_stall_clr;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_stall_next;

  assign w_req_id = bus.jump_flag_i | bus.hold_flag_ex_i | bus.hold_flag_clint_i
                  | (r_state != ST_RUN);
  assign w_hold   = hold_max(w_req_id ? c_HOLD_ID : c_HOLD_NONE,
                             bus.hold_flag_rib_i ? c_HOLD_PC : c_HOLD_NONE);

  // Redirect is a pure pass-through, forced quiet while reset is held.
  assign bus.jump_flag_o = (rst != c_RST_ENABLE) & bus.jump_flag_i;
  assign bus.jump_addr_o = bus.jump_flag_o ? bus.jump_addr_i : c_ZERO_WORD;
  assign bus.hold_flag_o = w_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == c_RST_ENABLE) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 4'd0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.jump_flag_i && (FLUSH_CYCLES > 0)) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= c_FLUSH_RELOAD;
          end else if (bus.jtag_halt_req_i) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (bus.jump_flag_i) begin
            r_flush_cnt <= c_FLUSH_RELOAD;
          end else if (r_flush_cnt == 4'd0) begin
            if (bus.jtag_halt_req_i) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        ST_HALT: begin
          if (!bus.jtag_halt_req_i) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Halted cycles are intentional, so they never feed the watchdog.
  assign w_stall_clr = (w_hold == c_HOLD_NONE) | (r_state == ST_HALT);

  pipe_hold_ctrl_sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (!w_stall_clr),
    .i_clr   (w_stall_clr),
    .o_count (w_stall_cnt),
    .o_next  (w_stall_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == c_RST_ENABLE)
      r_timeout <= 1'b0;
    else
      r_timeout <= (w_stall_next >= c_STALL_LIMIT);
  end

  assign bus.halted_o        = r_halted;
  assign bus.stall_timeout_o = r_timeout;
  assign bus.stall_cnt_o     = w_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hold_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_hold_ctrl : directed self-checking bench for pipe_hold_ctrl.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_hold_ctrl;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipe_hold_ctrl_if #(.CNT_W(16)) bus ();

  pipe_hold_ctrl #(
    .FLUSH_CYCLES (2),
    .STALL_LIMIT  (8),
    .CNT_W        (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic jf, input logic [31:0] ja, input logic ex,
                        input logic rib, input logic clint, input logic halt);
    bus.jump_flag_i       = jf;
    bus.jump_addr_i       = ja;
    bus.hold_flag_ex_i    = ex;
    bus.hold_flag_rib_i   = rib;
    bus.hold_flag_clint_i = clint;
    bus.jtag_halt_req_i   = halt;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "time budget exhausted");
  end

  initial begin
    rst = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    // During reset: hold follows inputs, redirect is forced low.
    set_in(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_hold",   32'(bus.hold_flag_o), 32'd3);
    chk("rst_jf",     32'(bus.jump_flag_o), 32'd0);
    chk("rst_ja",     bus.jump_addr_o,      32'h0);
    chk("rst_halted", 32'(bus.halted_o),    32'd0);
    chk("rst_cnt",    32'(bus.stall_cnt_o), 32'd0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick(); #1;
    chk("idle_hold", 32'(bus.hold_flag_o),     32'd0);
    chk("idle_jf",   32'(bus.jump_flag_o),     32'd0);
    chk("idle_to",   32'(bus.stall_timeout_o), 32'd0);

    // Single jump: jump cycle + two flush cycles.
    tick(); set_in(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("j1_jf",   32'(bus.jump_flag_o), 32'd1);
    chk("j1_ja",   bus.jump_addr_o,      32'h100);
    chk("j1_hold", 32'(bus.hold_flag_o), 32'd3);
    tick(); set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("j1_f1_hold", 32'(bus.hold_flag_o), 32'd3);
    chk("j1_f1_cnt",  32'(bus.stall_cnt_o), 32'd1);
    tick(); #1;
    chk("j1_f2_hold", 32'(bus.hold_flag_o), 32'd3);
    tick(); #1;
    chk("j1_end_hold", 32'(bus.hold_flag_o), 32'd0);
    chk("j1_end_cnt",  32'(bus.stall_cnt_o), 32'd3);
    chk("j1_end_ja",   bus.jump_addr_o,      32'h0);
    tick(); #1;
    chk("j1_clr_cnt", 32'(bus.stall_cnt_o), 32'd0);

    // Second jump in the first flush cycle reloads the flush run.
    tick(); set_in(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    tick(); set_in(1'b1, 32'h180, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("j2_ja",   bus.jump_addr_o,      32'h180);
    chk("j2_hold", 32'(bus.hold_flag_o), 32'd3);
    tick(); set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("j2_f1_hold", 32'(bus.hold_flag_o), 32'd3);
    tick(); #1;
    chk("j2_f2_hold", 32'(bus.hold_flag_o), 32'd3);
    tick(); #1;
    chk("j2_end_hold", 32'(bus.hold_flag_o), 32'd0);
    chk("j2_end_cnt",  32'(bus.stall_cnt_o), 32'd4);
    tick(); #1;

    // Request priority.
    tick(); set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0); #1;
    chk("pri_rib_ex", 32'(bus.hold_flag_o), 32'd3);
    tick(); set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    chk("pri_rib",     32'(bus.hold_flag_o), 32'd1);
    chk("pri_rib_cnt", 32'(bus.stall_cnt_o), 32'd1);
    tick(); set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    chk("pri_clint",   32'(bus.hold_flag_o), 32'd3);
    tick(); set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("pri_none",     32'(bus.hold_flag_o), 32'd0);
    chk("pri_none_cnt", 32'(bus.stall_cnt_o), 32'd3);
    tick(); #1;

    // Jump and halt together: flush first, then halt.
    tick(); set_in(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk("jh_hold",   32'(bus.hold_flag_o), 32'd3);
    chk("jh_halted", 32'(bus.halted_o),    32'd0);
    tick(); set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk("jh_f1_halted", 32'(bus.halted_o), 32'd0);
    tick(); #1;
    chk("jh_f2_halted", 32'(bus.halted_o),    32'd0);
    chk("jh_f2_hold",   32'(bus.hold_flag_o), 32'd3);
    tick(); set_in(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk("h_halted", 32'(bus.halted_o),    32'd1);
    chk("h_hold",   32'(bus.hold_flag_o), 32'd3);
    chk("h_cnt",    32'(bus.stall_cnt_o), 32'd3);
    chk("h_jf",     32'(bus.jump_flag_o), 32'd1);
    chk("h_ja",     bus.jump_addr_o,      32'h200);
    tick(); set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("h2_halted", 32'(bus.halted_o),    32'd1);
    chk("h2_hold",   32'(bus.hold_flag_o), 32'd3);
    chk("h2_cnt",    32'(bus.stall_cnt_o), 32'd0);
    tick(); set_in(1'b0, 32'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("hx_halted", 32'(bus.halted_o),    32'd0);
    chk("hx_hold",   32'(bus.hold_flag_o), 32'd0);
    chk("hx_ja",     bus.jump_addr_o,      32'h0);

    // Stall watchdog with limit 8.
    for (int k = 1; k <= 10; k++) begin
      tick(); set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      chk("wd_cnt", 32'(bus.stall_cnt_o),     32'(k - 1));
      chk("wd_to",  32'(bus.stall_timeout_o), (k >= 9) ? 32'd1 : 32'd0);
    end
    tick(); set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("wd_drop_hold", 32'(bus.hold_flag_o),     32'd0);
    chk("wd_drop_cnt",  32'(bus.stall_cnt_o),     32'd10);
    chk("wd_drop_to",   32'(bus.stall_timeout_o), 32'd1);
    tick(); #1;
    chk("wd_clr_cnt", 32'(bus.stall_cnt_o),     32'd0);
    chk("wd_clr_to",  32'(bus.stall_timeout_o), 32'd0);

    // Asynchronous reset mid-stall.
    for (int k = 1; k <= 10; k++) begin
      tick(); set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick(); #1;
    chk("ars_to_pre", 32'(bus.stall_timeout_o), 32'd1);
    #2; rst = 1'b0; #1;
    chk("ars_cnt",  32'(bus.stall_cnt_o),     32'd0);
    chk("ars_to",   32'(bus.stall_timeout_o), 32'd0);
    chk("ars_hold", 32'(bus.hold_flag_o),     32'd3);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    tick(); rst = 1'b1;

    // Asynchronous reset mid-flush.
    tick(); set_in(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    tick(); set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("arf_pre_hold", 32'(bus.hold_flag_o), 32'd3);
    #2; rst = 1'b0; #1;
    chk("arf_hold", 32'(bus.hold_flag_o), 32'd0);
    tick(); rst = 1'b1;
    tick(); #1;
    chk("arf_post_hold", 32'(bus.hold_flag_o), 32'd0);

    // Asynchronous reset mid-halt.
    tick(); set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk("arh_entry_halted", 32'(bus.halted_o), 32'd0);
    tick(); #1;
    chk("arh_pre_halted", 32'(bus.halted_o),    32'd1);
    chk("arh_pre_hold",   32'(bus.hold_flag_o), 32'd3);
    #2; rst = 1'b0; #1;
    chk("arh_halted", 32'(bus.halted_o),    32'd0);
    chk("arh_hold",   32'(bus.hold_flag_o), 32'd0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); rst = 1'b1;
    tick(); #1;
    chk("arh_post_halted", 32'(bus.halted_o),    32'd0);
    chk("arh_post_hold",   32'(bus.hold_flag_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
Pipeline hold/flush controller. It produces the hold_flag bus consumed by the pc_reg, if_id and id_ex pipeline registers, and the jump redirect sent to pc_reg. It arbitrates stall requests from ex, rib and clint, plus JTAG halt. After every taken jump it inserts a programmable run of flush bubbles, and it runs a stall watchdog.

Parameters:
FLUSH_CYCLES, 1, extra cycles Hold_Id is forced after the jump cycle (0..15; 0 = flush only in the jump cycle)
STALL_LIMIT, 1024, consecutive non-halt hold cycles before stall_timeout_o asserts
CNT_W, 16, width of the stall counter (STALL_LIMIT must be < 2^CNT_W)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
jump_flag_i  in  1  taken jump/branch/trap redirect from ex
jump_addr_i  in  32  redirect target (InstAddrBus)
hold_flag_ex_i  in  1  ex multi-cycle op busy (divider)
hold_flag_rib_i  in  1  bus arbiter busy
hold_flag_clint_i  in  1  interrupt entry in progress
jtag_halt_req_i  in  1  debug halt request (level)
hold_flag_o  out  3  Hold_Flag_Bus: Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3
jump_flag_o  out  1  redirect to pc_reg
jump_addr_o  out  32  redirect target to pc_reg
halted_o  out  1  core halted for debug
stall_timeout_o  out  1  watchdog flag
stall_cnt_o  out  CNT_W  current consecutive stall count

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, flush_cnt=0, stall_cnt=0; halted_o=0, stall_timeout_o=0, stall_cnt_o=0. During reset, hold_flag_o follows the combinational inputs; jump_flag_o=0 and jump_addr_o=0.
- jump_flag_o = jump_flag_i and jump_addr_o = jump_addr_i, both combinational, zero latency. jump_addr_o=ZeroWord whenever jump_flag_i=0.
- Request level, combinational. The level is the maximum of:
  - Hold_Id if jump_flag_i, hold_flag_ex_i or hold_flag_clint_i
  - Hold_Pc if hold_flag_rib_i
  - Hold_Id if state is FLUSH or HALT
  - otherwise Hold_None
- hold_flag_o = request level; never below the strongest request in the same cycle.
- FSM states: RUN, FLUSH, HALT.
- RUN:
  - jump_flag_i with FLUSH_CYCLES>0 -> FLUSH, flush_cnt=FLUSH_CYCLES-1.
  - else jtag_halt_req_i -> HALT. When jump and halt coincide, the jump wins and the halt is taken after the flush.
- FLUSH:
  - jump_flag_i reloads flush_cnt=FLUSH_CYCLES-1 and stays in FLUSH.
  - else if flush_cnt==0 -> HALT if jtag_halt_req_i, otherwise RUN.
  - else flush_cnt decrements by 1.
- HALT:
  - halted_o=1, registered, asserted the cycle after entry.
  - Exits to RUN when jtag_halt_req_i=0; halted_o drops the same cycle as the state change.
  - jump_flag_i during HALT still passes through, and the FSM stays in HALT.
- Stall counter:
  - Increments, saturating at 2^CNT_W-1, on each cycle hold_flag_o!=Hold_None while state!=HALT.
  - Clears to 0 on any cycle hold_flag_o==Hold_None or state==HALT.
  - stall_timeout_o is registered; it is 1 when stall_cnt >= STALL_LIMIT and drops the cycle after the counter clears.
- Reset asserted mid-FLUSH or mid-HALT returns immediately to RUN with all counters cleared.

Decomposition:
- The shared defines header already carries Hold_Flag_Bus, Hold_None/Pc/If/Id, InstAddrBus, ZeroWord, RstEnable; no new typedefs.
- Add the FSM state encodings (RUN=2'd0, FLUSH=2'd1, HALT=2'd2) to the defines header.
- One sub-module is natural: sat_counter (parameterised width, inc/clr, saturation), used for the stall watchdog.

Test Plan:
- Reset release with no requests -> hold_flag_o=0, jump_flag_o=0, halted_o=0, stall_cnt_o=0.
- FLUSH_CYCLES=2, jump_flag_i pulse with jump_addr_i=0x0000_0100 -> same cycle: jump_flag_o=1, jump_addr_o=0x100, hold_flag_o=3; then 3 for 2 more cycles; then 0.
- Second jump in the 1st flush cycle -> flush reloaded; hold_flag_o=3 for 2 further cycles counted from the second jump.
- hold_flag_rib_i=1 and hold_flag_ex_i=1 together -> hold_flag_o=3; with rib only -> 1.
- jtag_halt_req_i=1 in the same cycle as a jump -> FLUSH first, then HALT: halted_o=1, hold_flag_o=3. Deassert halt -> RUN; halted_o=0 the next cycle.
- STALL_LIMIT=8, hold_flag_ex_i held 10 cycles -> stall_timeout_o=1 from cycle 9; drop ex -> stall_cnt_o=0 and stall_timeout_o=0 one cycle later. Async rst mid-stall clears both immediately.
